// File: rtl/pla_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : pla_seq_eval
// Purpose  : Run-time programmable sum-of-products evaluator, one cube per clock.
// Revision : 1.0
// ============================================================================
module pla_seq_eval #(
    parameter int               N_IN       = 19,
    parameter int               N_OUT      = 10,
    parameter int               N_CUBES    = 256,
    parameter int               EARLY_EXIT = 1,
    parameter logic [N_OUT-1:0] OUT_POL    = '0,
    localparam int              AW         = $clog2(N_CUBES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic [N_OUT-1:0] cfg_omask,
    input  logic             cfg_count_we,
    input  logic [AW:0]      cfg_count,
    output logic             cfg_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y
);

    localparam logic [AW:0] c_MAX_COUNT = (AW+1)'(N_CUBES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N_IN-1:0]    r_x;
    logic [N_OUT-1:0]   r_acc;
    logic [AW-1:0]      r_idx;
    logic [AW:0]        r_count;

    logic [N_IN-1:0]    r_care_mem  [N_CUBES];
    logic [N_IN-1:0]    r_val_mem   [N_CUBES];
    logic [N_OUT-1:0]   r_omask_mem [N_CUBES];

    logic               w_cfg_ok;
    logic [AW:0]        w_count_sat;
    logic [AW:0]        w_count_eff;
    logic               w_match;
    logic [N_OUT-1:0]   w_acc_next;
    logic               w_last;
    logic               w_full;

    assign w_cfg_ok    = (r_state == S_IDLE);
    assign w_count_sat = (cfg_count > c_MAX_COUNT) ? c_MAX_COUNT : cfg_count;
    // A count written in the accept cycle already governs the vector being accepted.
    assign w_count_eff = (cfg_count_we && w_cfg_ok) ? w_count_sat : r_count;

    assign w_match    = (((r_x ^ r_val_mem[r_idx]) & r_care_mem[r_idx]) == '0);
    assign w_acc_next = r_acc | (w_match ? r_omask_mem[r_idx] : '0);
    assign w_last     = ({1'b0, r_idx} == (r_count - 1'b1));
    assign w_full     = (EARLY_EXIT != 0) && (&w_acc_next);

    always_ff @(posedge clk) begin
        if (cfg_we && w_cfg_ok) begin
            r_care_mem[cfg_addr]  <= cfg_care;
            r_val_mem[cfg_addr]   <= cfg_val;
            r_omask_mem[cfg_addr] <= cfg_omask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (cfg_count_we && w_cfg_ok) begin
                r_count <= w_count_sat;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= in_x;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_EVAL: begin
                    r_acc <= w_acc_next;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = (w_count_eff != '0) ? S_EVAL : S_DONE;
                end
            end
            S_EVAL: begin
                if (w_last || w_full) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign cfg_ready = w_cfg_ok;
    assign out_valid = (r_state == S_DONE);
    assign out_y     = out_valid ? (r_acc ^ OUT_POL) : '0;

endmodule
`default_nettype wire

// File: tb/tb_pla_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_pla_seq_eval
// Purpose  : Directed + randomized checks of pla_seq_eval against a cover model.
// Revision : 1.0
// ============================================================================
module tb_pla_seq_eval;

    localparam int         N_IN    = 19;
    localparam int         N_OUT   = 10;
    localparam int         N_CUBES = 256;
    localparam int         AW      = 8;
    localparam int         EE      = 1;
    localparam logic [9:0] POL     = 10'h000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [N_IN-1:0] cfg_care = '0;
    logic [N_IN-1:0] cfg_val = '0;
    logic [9:0]      cfg_omask = '0;
    logic            cfg_count_we = 1'b0;
    logic [AW:0]     cfg_count = '0;
    logic            cfg_ready;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N_IN-1:0] in_x = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [9:0]      out_y;

    pla_seq_eval #(
        .N_IN(N_IN), .N_OUT(N_OUT), .N_CUBES(N_CUBES),
        .EARLY_EXIT(EE), .OUT_POL(POL)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
        .cfg_val(cfg_val), .cfg_omask(cfg_omask),
        .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    always #5 clk = ~clk;

    // Reference cover: what the DUT should hold after every accepted write.
    logic [N_IN-1:0] m_care [N_CUBES];
    logic [N_IN-1:0] m_val  [N_CUBES];
    logic [9:0]      m_om   [N_CUBES];
    int              m_count = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [N_IN-1:0] x, output logic [9:0] y,
                                  output int lat);
        logic [9:0] acc = '0;
        int scanned = 0;
        for (int i = 0; i < m_count; i++) begin
            if (((x ^ m_val[i]) & m_care[i]) == '0) acc |= m_om[i];
            scanned = i + 1;
            if (EE != 0 && acc == 10'h3FF) break;
        end
        y   = acc ^ POL;
        lat = scanned + 1;
    endfunction

    task automatic model_count(input int c);
        m_count = (c > N_CUBES) ? N_CUBES : c;
    endtask

    task automatic write_cube(input int a, input logic [N_IN-1:0] c,
                              input logic [N_IN-1:0] v, input logic [9:0] o);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_care = c; cfg_val = v; cfg_omask = o;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_care[a] = c; m_val[a] = v; m_om[a] = o;
    endtask

    task automatic write_count(input int c);
        cfg_count_we = 1'b1; cfg_count = (AW+1)'(c);
        @(posedge clk); #1;
        cfg_count_we = 1'b0;
        model_count(c);
    endtask

    // One full transaction; optional config writes alongside the accept, an
    // optional (must-be-dropped) write during the scan, and a back-pressure hold.
    task automatic run_vec(input string tag, input logic [N_IN-1:0] x, input int hold,
                           input bit poke, input bit s_cube, input int a,
                           input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                           input logic [9:0] o, input bit s_cnt, input int cnt);
        logic [9:0] ey;
        logic [9:0] y0;
        int elat;
        int cyc;
        check({tag, ":in_ready_idle"}, {30'd0, in_ready, cfg_ready}, 32'd3);
        in_valid = 1'b1; in_x = x;
        if (s_cube) begin
            cfg_we = 1'b1; cfg_addr = AW'(a); cfg_care = c; cfg_val = v; cfg_omask = o;
        end
        if (s_cnt) begin
            cfg_count_we = 1'b1; cfg_count = (AW+1)'(cnt);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0; cfg_count_we = 1'b0;
        if (s_cube) begin
            m_care[a] = c; m_val[a] = v; m_om[a] = o;
        end
        if (s_cnt) model_count(cnt);
        model(x, ey, elat);
        cyc = 1;
        if (poke) begin
            cfg_we = 1'b1; cfg_addr = '0; cfg_care = '1; cfg_val = '0; cfg_omask = '0;
            cfg_count_we = 1'b1; cfg_count = '0;
        end
        while (!out_valid && cyc < 600) begin
            @(posedge clk); #1;
            cfg_we = 1'b0; cfg_count_we = 1'b0;
            cyc++;
        end
        if (poke) begin
            @(posedge clk); #1;
            cfg_we = 1'b0; cfg_count_we = 1'b0;
            cyc++;
        end
        check({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
        if (!poke) check({tag, ":latency"}, cyc, elat);
        check({tag, ":out_y"}, {22'd0, out_y}, {22'd0, ey});
        check({tag, ":busy_ready"}, {30'd0, in_ready, cfg_ready}, 32'd0);
        y0 = out_y;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ":hold"}, {21'd0, out_valid, in_ready, out_y}, {21'd0, 1'b1, 1'b0, y0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN-1:0] x, c, v;
        logic [9:0] o;
        int seen;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outs", {19'd0, out_valid, in_ready, cfg_ready, out_y},
              {19'd0, 1'b0, 1'b1, 1'b1, 10'h000});
        run_vec("empty_cover", 19'($urandom), 0, 0, 0, 0, '0, '0, '0, 0, 0);

        // Two-cube directed cover
        write_cube(0, 19'h00001, 19'h00000, 10'h001);
        write_cube(1, 19'h00002, 19'h00002, 10'h002);
        write_count(2);
        run_vec("two_cube_hit", 19'h00002, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        run_vec("two_cube_miss", 19'h00001, 0, 0, 0, 0, '0, '0, '0, 0, 0);

        // Early exit on an all-ones accumulator, with back-pressure and a dropped write
        write_cube(0, 19'h00000, 19'h00000, 10'h3FF);
        write_count(100);
        run_vec("early_exit", 19'($urandom), 0, 0, 0, 0, '0, '0, '0, 0, 0);
        run_vec("backpressure_poke", 19'($urandom), 5, 1, 0, 0, '0, '0, '0, 0, 0);
        run_vec("after_poke", 19'($urandom), 0, 0, 0, 0, '0, '0, '0, 0, 0);

        // Randomized covers, including writes landing on the accept edge
        for (int i = 0; i < 20; i++) begin
            c = 19'($urandom) & 19'($urandom) & 19'($urandom);
            o = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom);
            write_cube(i, c, 19'($urandom), o);
        end
        for (int t = 0; t < 24; t++) begin
            x = ($urandom_range(0, 1) == 1) ? (m_val[$urandom_range(0, 19)] ^ (19'd1 << $urandom_range(0, 18)))
                                            : 19'($urandom);
            c = 19'($urandom) & 19'($urandom);
            v = 19'($urandom);
            o = 10'($urandom);
            run_vec("rand", x, $urandom_range(0, 2), 0,
                    bit'($urandom_range(0, 1)), $urandom_range(0, 19), c, v, o,
                    bit'($urandom_range(0, 1)), $urandom_range(0, 20));
        end

        // Full-depth scan, count saturation, no early exit possible
        for (int i = 0; i < N_CUBES; i++) begin
            write_cube(i, 19'($urandom) & 19'($urandom), 19'($urandom), 10'($urandom) & 10'h1FF);
        end
        write_count(300);
        run_vec("sat_scan", 19'($urandom), 0, 0, 0, 0, '0, '0, '0, 0, 0);

        // Reset during a 50-cube scan discards the vector and clears the count
        write_count(50);
        in_valid = 1'b1; in_x = 19'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_count(0);
        check("rst_mid_idle", {30'd0, in_ready, out_valid}, 32'd2);
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("rst_mid_no_result", seen, 0);
        run_vec("post_rst", 19'($urandom), 0, 0, 0, 0, '0, '0, '0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
